// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg: carry-segmented pipelined adder.
// Each stage adds one SEG_W-wide slice of the operands plus the carry from
// the previous stage. The not-yet-added upper operand bits travel down the
// pipe while the completed lower sum bits accumulate. All stages share one
// advance enable, so a stalled output freezes the whole pipe, bubbles included.
module adder_pipe_seg #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG_W;
  localparam int LAST   = STAGES - 1;

  // The pipe moves only when the final stage is empty or being drained.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO_W  = gi * SEG_W;     // sum bits already completed upstream
    localparam int SRC_W = WIDTH - LO_W;   // operand bits still pending on entry
    localparam int HI_W  = SRC_W - SEG_W;  // operand bits still pending on exit

    logic                  v_src;
    logic                  c_src;
    logic                  sa_src;
    logic                  sb_src;
    logic [SRC_W-1:0]      a_src;
    logic [SRC_W-1:0]      b_src;
    logic [SEG_W:0]        seg_add;
    logic [LO_W+SEG_W-1:0] sum_d;
    logic [LO_W+SEG_W-1:0] sum_q;
    logic                  valid_d;
    logic                  valid_q;
    logic                  carry_d;
    logic                  carry_q;
    logic                  sa_d;
    logic                  sa_q;
    logic                  sb_d;
    logic                  sb_q;

    if (gi == 0) begin : g_src
      assign v_src  = in_valid;
      assign c_src  = cin;
      assign a_src  = a;
      assign b_src  = b;
      assign sa_src = a[WIDTH-1];
      assign sb_src = b[WIDTH-1];

      // First stage starts the sum with its own slice only.
      always_comb begin
        sum_d = seg_add[SEG_W-1:0];
      end
    end else begin : g_src
      assign v_src  = g_stage[gi-1].valid_q;
      assign c_src  = g_stage[gi-1].carry_q;
      assign a_src  = g_stage[gi-1].g_hi.a_hi_q;
      assign b_src  = g_stage[gi-1].g_hi.b_hi_q;
      assign sa_src = g_stage[gi-1].sa_q;
      assign sb_src = g_stage[gi-1].sb_q;

      // Append this stage's slice above the sum bits finished upstream.
      always_comb begin
        sum_d = {seg_add[SEG_W-1:0], g_stage[gi-1].sum_q};
      end
    end

    // Slice add with carry-in; the extra bit becomes the carry to the next stage.
    always_comb begin
      seg_add = {1'b0, a_src[SEG_W-1:0]} + {1'b0, b_src[SEG_W-1:0]}
              + {{SEG_W{1'b0}}, c_src};
      carry_d = seg_add[SEG_W];
      valid_d = v_src;
      sa_d    = sa_src;
      sb_d    = sb_src;
    end

    // Stage register: valid, carry, partial sum and operand sign bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
        sa_q    <= 1'b0;
        sb_q    <= 1'b0;
      end else if (advance) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
        sa_q    <= sa_d;
        sb_q    <= sb_d;
      end
    end

    // Upper operand slices only exist while some segments remain unadded.
    if (HI_W > 0) begin : g_hi
      logic [HI_W-1:0] a_hi_d;
      logic [HI_W-1:0] a_hi_q;
      logic [HI_W-1:0] b_hi_d;
      logic [HI_W-1:0] b_hi_q;

      // Drop the slice consumed here and forward the rest.
      always_comb begin
        a_hi_d = a_src[SRC_W-1:SEG_W];
        b_hi_d = b_src[SRC_W-1:SEG_W];
      end

      // Pending-operand register, held together with the rest of the stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (advance) begin
          a_hi_q <= a_hi_d;
          b_hi_q <= b_hi_d;
        end
      end
    end
  end

  // Results come straight from the final stage register.
  assign out_valid = g_stage[LAST].valid_q;
  assign sum       = g_stage[LAST].sum_q;
  assign cout      = g_stage[LAST].carry_q;
  assign ovf       = (g_stage[LAST].sa_q == g_stage[LAST].sb_q) &&
                     (g_stage[LAST].sum_q[WIDTH-1] != g_stage[LAST].sa_q);

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Testbench for adder_pipe_seg: directed cases plus randomized streams on
// three configurations, checked against an arithmetic reference model.
module tb_adder_pipe_seg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [2:0]  cin_v;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [31:0] sum_v [3];
  logic [31:0] sum0;
  logic [15:0] sum1;
  logic [23:0] sum2;

  assign sum_v[0] = sum0;
  assign sum_v[1] = {16'h0, sum1};
  assign sum_v[2] = {8'h0, sum2};

  int n_cmp = 0;
  int n_bad = 0;
  int widths [3] = '{32, 16, 24};

  adder_pipe_seg #(.WIDTH(32), .SEG_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  adder_pipe_seg #(.WIDTH(16), .SEG_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(cin_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  adder_pipe_seg #(.WIDTH(24), .SEG_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2][23:0]), .b(b_v[2][23:0]), .cin(cin_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: {cout, ovf, sum} from whole-word arithmetic at width w.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    logic [32:0] full;
    logic [31:0] mask;
    logic [31:0] s;
    logic        co;
    logic        ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full = {1'b0, a & mask} + {1'b0, b & mask} + {32'h0, c};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {co, ov, s};
  endfunction

  // Single operand on instance 0 with out_ready high: latency and result.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] want_sum, input logic want_cout,
                          input logic want_ovf, input string tag);
    int lat;
    @(negedge clk);
    a_v[0] = a; b_v[0] = b; cin_v[0] = c;
    in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    #1 check_val({tag, "_rdy"}, {63'h0, in_ready_v[0]}, 64'h1);
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    lat = 0;
    while (!out_valid_v[0] && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'd3);
    check_val({tag, "_res"}, {30'h0, cout_v[0], ovf_v[0], sum_v[0]},
              {30'h0, want_cout, want_ovf, want_sum});
    $display("txn %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             tag, a, b, c, sum_v[0], cout_v[0], ovf_v[0], lat + 1);
    @(posedge clk);
    #1 check_val({tag, "_gone"}, {63'h0, out_valid_v[0]}, 64'h0);
  endtask

  // Stream n_items through instance idx; rand_mode=0 stalls cycles 5-7.
  task automatic run_stream(input int idx, input int n_items, input bit rand_mode);
    logic [33:0] exp_q [$];
    logic [33:0] obs;
    logic [33:0] prev_out;
    logic [33:0] want;
    bit          prev_stalled;
    int          sent;
    int          got;
    int          cyc;
    int          w;
    w = widths[idx];
    sent = 0; got = 0; cyc = 0; prev_stalled = 1'b0; prev_out = '0;
    while (got < n_items && cyc < 4000) begin
      @(negedge clk);
      obs = {cout_v[idx], ovf_v[idx], sum_v[idx]};
      if (prev_stalled) check_val($sformatf("hold%0d", idx), 64'(obs), 64'(prev_out));
      if (rand_mode) begin
        out_ready_v[idx] = ($urandom_range(0, 3) != 0);
        in_valid_v[idx]  = (sent < n_items) && ($urandom_range(0, 3) != 0);
        a_v[idx] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        b_v[idx] = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : 32'($urandom);
      end else begin
        out_ready_v[idx] = !(cyc >= 5 && cyc <= 7);
        in_valid_v[idx]  = (sent < n_items);
        a_v[idx] = 32'($urandom);
        b_v[idx] = 32'($urandom);
      end
      cin_v[idx] = 1'($urandom_range(0, 1));
      #1;
      if (!rand_mode && cyc >= 5 && cyc <= 7) begin
        check_val("stall_vld", {63'h0, out_valid_v[idx]}, 64'h1);
        check_val("stall_rdy", {63'h0, in_ready_v[idx]}, 64'h0);
      end
      check_val($sformatf("rdy%0d", idx), {63'h0, in_ready_v[idx]},
                {63'h0, !out_valid_v[idx] || out_ready_v[idx]});
      if (out_valid_v[idx] && out_ready_v[idx]) begin
        check_val($sformatf("qlen%0d", idx), {63'h0, exp_q.size() != 0}, 64'h1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check_val($sformatf("res%0d", idx), 64'(obs), 64'(want));
          $display("txn inst%0d #%0d: sum=%h cout=%0d ovf=%0d", idx, got,
                   obs[31:0], obs[33], obs[32]);
        end
        got++;
      end
      if (in_valid_v[idx] && in_ready_v[idx]) begin
        exp_q.push_back(ref_add(w, a_v[idx], b_v[idx], cin_v[idx]));
        sent++;
      end
      prev_stalled = out_valid_v[idx] && !out_ready_v[idx];
      prev_out = obs;
      cyc++;
    end
    @(negedge clk);
    in_valid_v[idx] = 1'b0;
    out_ready_v[idx] = 1'b1;
    check_val($sformatf("count%0d", idx), 64'(got), 64'(n_items));
    check_val($sformatf("left%0d", idx), 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    in_valid_v = '0; out_ready_v = '0; cin_v = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0; b_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_val("rst_ovld", {61'h0, out_valid_v}, 64'h0);
    check_val("rst_irdy", {61'h0, in_ready_v}, 64'h7);
    check_val("rst_sum", {32'h0, sum0}, 64'h0);
    check_val("rst_flags", {58'h0, cout_v, ovf_v}, 64'h0);
    rst_n = 1'b1;
    out_ready_v = 3'b111;

    send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "carry8");
    send_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "wrap");
    send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf");

    run_stream(0, 8, 1'b0);

    // Three operands in flight, oldest reaching the output, then reset.
    @(negedge clk);
    in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_v[0] = 32'($urandom); b_v[0] = 32'($urandom);
      @(negedge clk);
    end
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    check_val("pre_rst_vld", {63'h0, out_valid_v[0]}, 64'h1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async_vld", {63'h0, out_valid_v[0]}, 64'h0);
    check_val("rst_async_sum", {32'h0, sum0}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_one(32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, "post_rst");
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (out_valid_v[0]) seen++;
    end
    check_val("residue", 64'(seen), 64'h0);

    run_stream(0, 200, 1'b1);
    run_stream(1, 200, 1'b1);
    run_stream(2, 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
